float_type_stat: RTL and testbench
==================================

# float_type_stat

Streaming IEEE-754 single-precision classification stage with statistics. Consumes 32-bit words over a valid/ready handshake, buffers them in a 2-entry FIFO, and emits each word with its registered one-hot class (zero / normal / subnormal / infinity / NaN). It keeps five per-class occurrence counters. It sits directly downstream of the data source and replaces ad-hoc combinational classification in the datapath with a registered, back-pressurable stage.

## Interface
- `CNT_W`, default 16: width of each per-class counter; legal range 4..32.

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  stage can accept a word.
- `in_num`  in  32  IEEE-754 single-precision word.
- `out_valid`  out  1  head word valid.
- `out_ready`  in  1  downstream accepts head word.
- `out_num`  out  32  head word, unmodified.
- `out_type`  out  5  one-hot class of head word.
- `clr`  in  1  synchronous clear of all counters.
- `cnt_zero`, `cnt_norm`, `cnt_sub`, `cnt_inf`, `cnt_nan`  out  CNT_W each  per-class accepted-word counts.

## Operation
- Class encoding, with `exp`=num[30:23] and `frac`=num[22:0]; the sign bit is ignored:
  - bit0 zero: exp=0, frac=0.
  - bit1 normal: exp in 1..254.
  - bit2 subnormal: exp=0, frac≠0.
  - bit3 inf: exp=255, frac=0.
  - bit4 NaN: exp=255, frac≠0.
  - Exactly one bit is set for every valid entry.
- Class is computed at accept time and stored alongside the word in the FIFO entry (37 bits per entry).
- Handshake:
  - Accept when `in_valid && in_ready`.
  - Pop when `out_valid && out_ready`.
  - `in_valid` has no effect while `in_ready`=0.
  - Producer holds `in_num` until accepted; the stage holds `out_num`/`out_type` until popped.
- Occupancy states and transitions:
  - EMPTY: accept → ONE.
  - ONE: accept only → FULL; pop only → EMPTY; accept+pop → ONE, with the new word becoming head on the next cycle.
  - FULL: pop → ONE; no accept in FULL.
- Output decodes: `in_ready` = (state≠FULL); `out_valid` = (state≠EMPTY).
- Order is strictly FIFO; the 2-entry storage uses a 1-bit read pointer and a 1-bit write pointer that wrap.
- Counters:
  - On each accept, the counter of the accepted word's class increments by 1.
  - Pops do not affect counters.
  - `clr`=1 forces all five counters to 0. `clr` has priority over a same-cycle accept, so that word is not counted.
  - `clr` does not affect the FIFO.
- Wrap/saturation at all-ones is set by configuration.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert is the integrator's responsibility):
  - state EMPTY, pointers 0.
  - `out_valid`=0, `out_num`=0, `out_type`=0, `in_ready`=1.
  - All counters 0.
- Reset mid-transfer discards buffered words without popping them.
- Latency: a word accepted at edge N appears on `out_num`/`out_type` with `out_valid`=1 from edge N (visible in cycle N+1). There is no combinational input-to-output path.
- Counters update at the accepting edge and are visible the cycle after acceptance.
- Throughput: 1 word/cycle while `out_ready`=1. If continuous input persists and `out_ready`=0 for 2+ cycles, `in_ready` drops after two accepts.
- `in_ready` is a pure function of registered state and never depends combinationally on `out_ready`.

## Configuration
- `FLOAT_STAT_SAT_EN` defined: a counter at 2^CNT_W−1 stays there on further increments.
- `FLOAT_STAT_SAT_EN` undefined: a counter at 2^CNT_W−1 wraps to 0 on the next increment.
- The FIFO and classification are identical in both builds.

## Test plan
- Class sweep: with `out_ready`=1, feed 0x00000000, 0x80000000, 0x3F800000, 0x00000001, 0x7F800000, 0xFF800000, 0x7FC00000.
  - `out_type`: 00001, 00001, 00010, 00100, 01000, 01000, 10000.
  - Final counts: zero=2, norm=1, sub=1, inf=2, nan=1.
- Back-pressure: `out_ready`=0 with `in_valid`=1 continuous.
  - Two accepts, then `in_ready`=0.
  - Raise `out_ready`: words emerge in order, and `in_ready` returns 1 the cycle after the first pop.
- Simultaneous accept+pop in ONE: state stays ONE, order is preserved, and there is no bubble over a 10-word stream with `out_ready`=1.
- `clr` coincident with accept of 0x3F800000: all counters read 0 next cycle, and the word still appears on the output with `out_type`=00010.
- Overflow with CNT_W=4: accept 16 normal words.
  - With `FLOAT_STAT_SAT_EN`: `cnt_norm`=15.
  - Without: `cnt_norm`=0.
- Reset asserted while FULL: `out_valid`=0, `in_ready`=1 and counters 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/float_type_stat.sv
// float_type_stat
//   Registered IEEE-754 single-precision classification stage. Words enter
//   over a valid/ready handshake and are held in a 2-entry FIFO. Each entry
//   stores the word together with its one-hot class: {class[4:0], word[31:0]}.
//   Five per-class counters record every accepted word.
//
//   Class bits: 0 zero, 1 normal, 2 subnormal, 3 infinity, 4 NaN. The sign
//   bit is ignored.
//
//   Build option: FLOAT_STAT_SAT_EN
//     defined   - counters saturate at all-ones
//     undefined - counters wrap to zero after all-ones
//
// Ports
//   clk, reset                 clock; asynchronous active-low reset
//   in_valid/in_ready/in_num   upstream word handshake
//   out_valid/out_ready        downstream handshake for the head word
//   out_num/out_type           head word and its one-hot class
//   clr                        synchronous clear of all counters (wins over
//                              a same-cycle accept)
//   cnt_*                      per-class accepted-word counts
module float_type_stat #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_num,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_num,
    output logic [4:0]       out_type,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt_zero,
    output logic [CNT_W-1:0] cnt_norm,
    output logic [CNT_W-1:0] cnt_sub,
    output logic [CNT_W-1:0] cnt_inf,
    output logic [CNT_W-1:0] cnt_nan
);

    // state | meaning
    // EMPTY | no word buffered; head outputs invalid
    // ONE   | one word buffered; can accept and pop in the same cycle
    // FULL  | both entries occupied; upstream is stalled
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t      state;
    logic [36:0] mem [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [4:0]  in_class;
    logic        accept;
    logic        pop;
    logic [36:0] head;

    logic [CNT_W-1:0] cnt [5];

    function automatic logic [4:0] classify(input logic [31:0] num);
        logic [7:0]  e;
        logic [22:0] f;
        e = num[30:23];
        f = num[22:0];
        if (e == 8'd0)
            classify = (f == 23'd0) ? 5'b00001 : 5'b00100;
        else if (e == 8'hFF)
            classify = (f == 23'd0) ? 5'b01000 : 5'b10000;
        else
            classify = 5'b00010;
    endfunction

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c);
`ifdef FLOAT_STAT_SAT_EN
        bump = (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
`else
        bump = c + CNT_W'(1);
`endif
    endfunction

    assign in_class  = classify(in_num);
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Head is read straight from registered storage, so nothing on the input
    // side reaches the outputs combinationally.
    assign head     = mem[rd_ptr];
    assign out_num  = head[31:0];
    assign out_type = head[36:32];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= EMPTY;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= {in_class, in_num};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case (state)
                EMPTY: if (accept) state <= ONE;
                ONE: begin
                    if (accept && !pop)
                        state <= FULL;
                    else if (pop && !accept)
                        state <= EMPTY;
                end
                FULL: if (pop) state <= ONE;
                default: state <= EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 5; i++)
                cnt[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < 5; i++)
                cnt[i] <= '0;
        end else if (accept) begin
            for (int i = 0; i < 5; i++)
                if (in_class[i])
                    cnt[i] <= bump(cnt[i]);
        end
    end

    assign cnt_zero = cnt[0];
    assign cnt_norm = cnt[1];
    assign cnt_sub  = cnt[2];
    assign cnt_inf  = cnt[3];
    assign cnt_nan  = cnt[4];

endmodule

// File: tb/tb_float_type_stat.sv
module tb_float_type_stat;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic clr = 1'b0;
    logic [31:0] in_num = '0;
    logic in_ready, out_valid;
    logic [31:0] out_num;
    logic [4:0] out_type;
    logic [CNT_W-1:0] cnt_zero, cnt_norm, cnt_sub, cnt_inf, cnt_nan;

    float_type_stat #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_num(in_num),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_num(out_num), .out_type(out_type),
        .clr(clr),
        .cnt_zero(cnt_zero), .cnt_norm(cnt_norm), .cnt_sub(cnt_sub),
        .cnt_inf(cnt_inf), .cnt_nan(cnt_nan)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    logic [36:0] sbq[$];
    int mcnt[5];
    bit mon_en = 0;
    bit last_acc = 0;

    // Reference classification from the IEEE-754 field rules.
    function automatic logic [4:0] ref_class(input logic [31:0] n);
        int e, f;
        e = int'(n[30:23]);
        f = int'(n[22:0]);
        if (e == 0)   return (f == 0) ? 5'd1 : 5'd4;
        if (e == 255) return (f == 0) ? 5'd8 : 5'd16;
        return 5'd2;
    endfunction

    function automatic int ref_bump(input int c);
`ifdef FLOAT_STAT_SAT_EN
        return (c >= CMAX) ? CMAX : c + 1;
`else
        return (c + 1) % (CMAX + 1);
`endif
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int cls_idx(input logic [4:0] c);
        for (int i = 0; i < 5; i++) if (c[i]) return i;
        return 0;
    endfunction

    // Monitor: at the falling edge the handshake signals describe what the
    // next rising edge will do.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            check("cnt_zero", cnt_zero, mcnt[0]);
            check("cnt_norm", cnt_norm, mcnt[1]);
            check("cnt_sub",  cnt_sub,  mcnt[2]);
            check("cnt_inf",  cnt_inf,  mcnt[3]);
            check("cnt_nan",  cnt_nan,  mcnt[4]);
            if (out_valid && out_ready) begin
                check("pop_with_data", sbq.size() != 0, 1);
                if (sbq.size() != 0) begin
                    logic [36:0] e;
                    e = sbq.pop_front();
                    check("out_num",  out_num,  e[31:0]);
                    check("out_type", out_type, e[36:32]);
                end
            end
            last_acc = in_valid && in_ready;
            if (in_valid && in_ready) sbq.push_back({ref_class(in_num), in_num});
            if (clr) begin
                for (int i = 0; i < 5; i++) mcnt[i] = 0;
            end else if (in_valid && in_ready) begin
                int k;
                k = cls_idx(ref_class(in_num));
                mcnt[k] = ref_bump(mcnt[k]);
            end
        end
    end

    function automatic logic [31:0] rand_word(input int cls);
        logic [31:0] w;
        w = $urandom;
        case (cls)
            0: w[30:0] = '0;
            1: w[30:23] = 8'($urandom_range(1, 254));
            2: begin w[30:23] = 8'd0; if (w[22:0] == 0) w[0] = 1'b1; end
            3: begin w[30:23] = 8'hFF; w[22:0] = '0; end
            default: begin w[30:23] = 8'hFF; if (w[22:0] == 0) w[22] = 1'b1; end
        endcase
        return w;
    endfunction

    task automatic send(input logic [31:0] w);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_num = w;
        @(negedge clk);
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        check("send_no_timeout", n < 50, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (out_valid && n < 20) begin @(posedge clk); #1; n++; end
        check("drain_done", out_valid, 0);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    logic [31:0] sweep [7] = '{32'h00000000, 32'h80000000, 32'h3F800000,
                               32'h00000001, 32'h7F800000, 32'hFF800000,
                               32'h7FC00000};

    initial begin
        for (int i = 0; i < 5; i++) mcnt[i] = 0;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_num", out_num, 0);
        check("rst_out_type", out_type, 0);
        check("rst_cnt_sum", cnt_zero + cnt_norm + cnt_sub + cnt_inf + cnt_nan, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1;

        // class sweep
        out_ready = 1'b1;
        foreach (sweep[i]) send(sweep[i]);
        idle(2);
        @(negedge clk);
        check("sweep_zero", cnt_zero, 2);
        check("sweep_norm", cnt_norm, 1);
        check("sweep_sub",  cnt_sub,  1);
        check("sweep_inf",  cnt_inf,  2);
        check("sweep_nan",  cnt_nan,  1);
        @(posedge clk); #1;

        // back-pressure
        out_ready = 1'b0;
        in_valid = 1'b1; in_num = 32'h40000000;
        @(negedge clk); check("bp_ready0", in_ready, 1);
        @(posedge clk); #1; in_num = 32'h40400000;
        @(negedge clk); check("bp_ready1", in_ready, 1);
        @(posedge clk); #1; in_num = 32'h40800000;
        @(negedge clk); check("bp_full", in_ready, 0);
        @(posedge clk); #1;
        @(negedge clk); check("bp_still_full", in_ready, 0);
        @(posedge clk); #1; out_ready = 1'b1;
        @(negedge clk); check("bp_before_pop", in_ready, 0);
        @(posedge clk); #1;
        @(negedge clk); check("bp_after_pop", in_ready, 1);
        @(posedge clk); #1; in_valid = 1'b0;
        drain();

        // 10-word stream without bubbles
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_num = rand_word($urandom_range(0, 4));
            @(negedge clk);
            check("stream_in_ready", in_ready, 1);
            if (i > 0) check("stream_out_valid", out_valid, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();

        // clr coincident with accept
        clr = 1'b1; in_valid = 1'b1; in_num = 32'h3F800000;
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("clr_cnt_sum", cnt_zero + cnt_norm + cnt_sub + cnt_inf + cnt_nan, 0);
        check("clr_out_valid", out_valid, 1);
        check("clr_out_type", out_type, 5'b00010);
        @(posedge clk); #1;
        drain();

        // counter overflow
        do_clr();
        for (int i = 0; i < 16; i++) send(rand_word(1));
        idle(1);
        @(negedge clk);
`ifdef FLOAT_STAT_SAT_EN
        check("ovf_norm", cnt_norm, 15);
`else
        check("ovf_norm", cnt_norm, 0);
`endif
        @(posedge clk); #1;

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 39) == 0);
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 2) != 0);
                in_num = rand_word($urandom_range(0, 4));
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; clr = 1'b0;
        drain();

        // asynchronous reset while FULL
        out_ready = 1'b0;
        send(32'h3F800000);
        send(32'h7F800000);
        @(negedge clk); check("pre_rst_full", in_ready, 0);
        @(posedge clk); #2;
        mon_en = 0;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_cnt_sum", cnt_zero + cnt_norm + cnt_sub + cnt_inf + cnt_nan, 0);
        sbq.delete();
        for (int i = 0; i < 5; i++) mcnt[i] = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1;
        out_ready = 1'b1;
        send(32'h00000001);
        drain();
        idle(2);
        check("sb_empty_end", sbq.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
